// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO write arbiter.
// Imported by the arbiter top and its round-robin picker.
package fifo_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BURST,
    SETTLE
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int len_w(input int max_burst);
    return clog2(max_burst + 1);
  endfunction

  function automatic int idx_w(input int n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_write_arbiter_rr_pick.sv
// Round-robin priority search: first set bit of mask_i at or
// after ptr_i, wrapping around.
module fifo_write_arbiter_rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  mask_i,
  input  logic [IW-1:0] ptr_i,
  output logic [IW-1:0] idx_o,
  output logic          found_o
);

  int j;

  // Walk from the farthest slot back to ptr so the nearest hit wins.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    j       = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(ptr_i) + k) % N;
      if (mask_i[j]) begin
        idx_o   = IW'(j);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Burst-atomic round-robin arbiter sharing one FIFO write port
// among NUM_REQ producers in the write-clock domain.
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int MAX_BURST  = 8,
  localparam int LEN_W     = len_w(MAX_BURST),
  localparam int IDX_W     = idx_w(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*LEN_W-1:0]      req_len,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            grant,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
  output logic                          fifo_wr_en,
  input  logic [ADDR_WIDTH:0]           fifo_count,
  input  logic                          fifo_full,
  output logic                          busy,
  output logic                          len_err
);

  localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH + 1)'(2 ** ADDR_WIDTH);
  localparam logic [LEN_W-1:0]    MAXL  = LEN_W'(MAX_BURST);
  localparam logic [IDX_W-1:0]    LAST  = IDX_W'(NUM_REQ - 1);

  state_e              state_q;
  logic [NUM_REQ-1:0]  grant_q;
  logic [IDX_W-1:0]    gidx_q;
  logic [IDX_W-1:0]    rr_q;
  logic [LEN_W-1:0]    cnt_q;
  logic                err_q;

  logic [IDX_W-1:0]    pick;
  logic                found;
  logic [LEN_W-1:0]    plen;
  logic [ADDR_WIDTH:0] space;
  logic                len_ok;
  logic                fits;
  logic [IDX_W-1:0]    rr_d;

  fifo_write_arbiter_rr_pick #(
    .N  (NUM_REQ),
    .IW (IDX_W)
  ) u_pick (
    .mask_i  (req),
    .ptr_i   (rr_q),
    .idx_o   (pick),
    .found_o (found)
  );

  assign plen   = req_len[int'(pick)*LEN_W +: LEN_W];
  assign space  = DEPTH - fifo_count;
  assign len_ok = (plen != '0) && (plen <= MAXL);
  assign fits   = 32'(space) >= 32'(plen);
  assign rr_d   = (pick == LAST) ? '0 : pick + 1'b1;

  assign grant        = grant_q;
  assign busy         = (state_q != IDLE);
  assign len_err      = err_q;
  assign req_ready    = grant_q & {NUM_REQ{~fifo_full}};
  assign fifo_wr_en   = (state_q == BURST) & req_valid[gidx_q] & ~fifo_full;
  assign fifo_wr_data = req_data[int'(gidx_q)*DATA_WIDTH +: DATA_WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          // A short-space head-of-line requester blocks later ones.
          if (found && !len_ok) begin
            err_q <= 1'b1;
            rr_q  <= rr_d;
          end else if (found && fits) begin
            grant_q <= NUM_REQ'(1) << pick;
            gidx_q  <= pick;
            cnt_q   <= plen;
            rr_q    <= rr_d;
            state_q <= BURST;
          end
        end
        BURST: begin
          if (fifo_wr_en) begin
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == LEN_W'(1)) begin
              grant_q <= '0;
              state_q <= SETTLE;
            end
          end
        end
        SETTLE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Scoreboard bench: a transaction-level arbiter/FIFO model predicts
// every cycle's outputs; a separate monitor compares them.
module tb_fifo_write_arbiter;

  localparam int N     = 4;
  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int MB    = 8;
  localparam int LW    = 4;
  localparam int DEPTH = 16;

  typedef struct {
    int            cyc;
    logic [N-1:0]  grant;
    logic [N-1:0]  ready;
    logic          busy;
    logic          err;
    logic          wr;
    logic [DW-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [N-1:0]    req;
  logic [N*LW-1:0] req_len;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    grant;
  logic [DW-1:0]   fifo_wr_data;
  logic            fifo_wr_en;
  logic [AW:0]     fifo_count;
  logic            fifo_full;
  logic            busy;
  logic            len_err;

  fifo_write_arbiter #(
    .NUM_REQ    (N),
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .MAX_BURST  (MB)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .req_len      (req_len),
    .req_data     (req_data),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .grant        (grant),
    .fifo_wr_data (fifo_wr_data),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_count   (fifo_count),
    .fifo_full    (fifo_full),
    .busy         (busy),
    .len_err      (len_err)
  );

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  exp_t          cq[$];
  exp_t          me;
  int            blen[N][$];
  logic [DW-1:0] bdat[N][$];

  // Reference model: who owns the port, beats left, settle/err flags.
  int m_owner  = -1;
  int m_left   = 0;
  int m_ptr    = 0;
  bit m_settle = 1'b0;
  bit m_err    = 1'b0;
  int occ      = 0;
  int vprob    = 100;
  int rprob    = 0;

  function automatic void chk(input string nm, input int c,
                              input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      if (fails <= 40)
        $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, c, act, exp);
    end
  endfunction

  function automatic bit pending();
    for (int i = 0; i < N; i++)
      if (blen[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic add_burst(input int r, input int len);
    blen[r].push_back(len);
    if (len >= 1 && len <= MB)
      repeat (len) bdat[r].push_back(DW'($urandom));
  endtask

  task automatic step(input bit do_rst);
    exp_t e;
    bit   rd;
    bit   nerr;
    int   o;
    int   j;
    int   l;
    @(posedge clk);
    #1;
    cyc++;
    rst = do_rst;
    for (int i = 0; i < N; i++) begin
      req[i] = blen[i].size() > 0;
      req_len[i*LW +: LW] = req[i] ? LW'(blen[i][0]) : LW'($urandom_range(15));
      req_valid[i] = $urandom_range(99) < vprob;
      req_data[i*DW +: DW] = (bdat[i].size() > 0) ? bdat[i][0] : DW'($urandom);
    end
    fifo_count = (AW + 1)'(occ);
    fifo_full  = occ >= DEPTH;

    o       = m_owner;
    e.cyc   = cyc;
    e.grant = (o >= 0) ? (N'(1) << o) : '0;
    e.ready = (occ < DEPTH) ? e.grant : '0;
    e.busy  = (o >= 0) || m_settle;
    e.err   = m_err;
    e.wr    = (o >= 0) && req_valid[o] && (occ < DEPTH);
    e.data  = e.wr ? bdat[o][0] : '0;
    cq.push_back(e);

    rd = (occ > 0) && ($urandom_range(99) < rprob);
    if (e.wr) begin
      void'(bdat[o].pop_front());
      m_left--;
    end
    nerr = 1'b0;
    if (do_rst) begin
      if (o >= 0) begin
        repeat (m_left) void'(bdat[o].pop_front());
        void'(blen[o].pop_front());
      end
      m_owner  = -1;
      m_left   = 0;
      m_ptr    = 0;
      m_settle = 1'b0;
    end else if (o >= 0) begin
      if (m_left == 0) begin
        void'(blen[o].pop_front());
        m_owner  = -1;
        m_settle = 1'b1;
      end
    end else if (m_settle) begin
      m_settle = 1'b0;
    end else begin
      for (int k = 0; k < N; k++) begin
        j = (m_ptr + k) % N;
        if (blen[j].size() > 0) begin
          l = blen[j][0];
          if (l < 1 || l > MB) begin
            nerr = 1'b1;
            void'(blen[j].pop_front());
            m_ptr = (j + 1) % N;
          end else if (DEPTH - occ >= l) begin
            m_owner = j;
            m_left  = l;
            m_ptr   = (j + 1) % N;
          end
          break;
        end
      end
    end
    m_err = nerr;
    occ   = occ + int'(e.wr) - int'(rd);
  endtask

  task automatic run(input int lim);
    int n;
    n = 0;
    while ((pending() || m_owner >= 0 || m_settle || m_err) && n < lim) begin
      step(1'b0);
      n++;
    end
    checks++;
    if (n >= lim) begin
      fails++;
      $display("FAIL drain_timeout cyc=%0d got=busy exp=idle", cyc);
    end
  endtask

  task automatic scen_start();
    occ   = 0;
    vprob = 100;
    rprob = 0;
    step(1'b1);
    step(1'b0);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (cq.size() > 0) begin
        me = cq.pop_front();
        chk("grant", me.cyc, 32'(grant), 32'(me.grant));
        chk("req_ready", me.cyc, 32'(req_ready), 32'(me.ready));
        chk("busy", me.cyc, 32'(busy), 32'(me.busy));
        chk("len_err", me.cyc, 32'(len_err), 32'(me.err));
        chk("wr_en", me.cyc, 32'(fifo_wr_en), 32'(me.wr));
        if (me.wr)
          chk("wr_data", me.cyc, 32'(fifo_wr_data), 32'(me.data));
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
    $fatal(1);
  end

  initial begin
    rst        = 1'b1;
    req        = '0;
    req_len    = '0;
    req_data   = '0;
    req_valid  = '0;
    fifo_count = '0;
    fifo_full  = 1'b0;
    repeat (2) @(posedge clk);

    scen_start();
    add_burst(0, 3);
    run(50);

    scen_start();
    for (int i = 0; i < N; i++) add_burst(i, 1);
    add_burst(0, 1);
    run(60);

    scen_start();
    occ = 14;
    add_burst(1, 4);
    add_burst(2, 1);
    repeat (4) step(1'b0);
    occ   = 12;
    rprob = 20;
    run(400);

    scen_start();
    vprob = 50;
    add_burst(1, 4);
    run(100);

    scen_start();
    add_burst(0, 5);
    repeat (3) step(1'b0);
    step(1'b1);
    add_burst(3, 2);
    run(50);

    scen_start();
    add_burst(2, 0);
    add_burst(3, 2);
    run(50);

    scen_start();
    vprob = 70;
    rprob = 40;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(99) < 30) begin
        int r;
        r = $urandom_range(N - 1);
        if (blen[r].size() < 2) begin
          if ($urandom_range(99) < 90) add_burst(r, $urandom_range(MB, 1));
          else if ($urandom_range(1) == 0) add_burst(r, 0);
          else add_burst(r, $urandom_range(15, MB + 1));
        end
      end
      step(($urandom_range(499) == 0) ? 1'b1 : 1'b0);
    end
    run(2000);

    @(negedge clk);
    #1;
    chk("scoreboard_drained", cyc, 32'(cq.size()), 32'd0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
